// File: rtl/mc_sequencer_if.sv
// ---------------------------------------------------------------------------
// mc_sequencer_if
// Bundle between the multicycle control sequencer and its datapath.
//   From datapath : op[5:0], funct[5:0], zero, memready
//   To datapath   : iord, irwrite, memwrite, regwrite, pcen, regdst,
//                   memtoreg, alusrca, alusrcb[1:0], pcsrc[1:0],
//                   alucontrol[2:0], state[3:0], instrdone
// master = sequencer side, slave = datapath side.
// ---------------------------------------------------------------------------
interface mc_sequencer_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memready;
    logic       iord;
    logic       irwrite;
    logic       memwrite;
    logic       regwrite;
    logic       pcen;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       instrdone;

    modport master (
        input  op, funct, zero, memready,
        output iord, irwrite, memwrite, regwrite, pcen, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state, instrdone
    );

    modport slave (
        output op, funct, zero, memready,
        input  iord, irwrite, memwrite, regwrite, pcen, regdst, memtoreg,
               alusrca, alusrcb, pcsrc, alucontrol, state, instrdone
    );
endinterface

// File: rtl/mc_sequencer.sv
// ---------------------------------------------------------------------------
// mc_sequencer
// Control FSM for a multicycle MIPS-style datapath (lw, sw, R-type, beq,
// bne, addi, ori, j). Only the state register is sequential; every control
// output is decoded combinationally from state, op, funct, zero, memready.
//   clk   : clock, rising edge
//   reset : synchronous active-high reset
//   bus   : mc_sequencer_if.master (opcode/flags in, control strobes out)
// ---------------------------------------------------------------------------
module mc_sequencer (
    input  logic                  clk,
    input  logic                  reset,
    mc_sequencer_if.master        bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;

    // Returns {mapped, alucontrol}; unmapped functs report 0 with add.
    function automatic logic [3:0] funct_map(input logic [5:0] f);
        case (f)
            6'b100000: funct_map = 4'b1_010;
            6'b100010: funct_map = 4'b1_110;
            6'b100100: funct_map = 4'b1_000;
            6'b100101: funct_map = 4'b1_001;
            6'b101010: funct_map = 4'b1_111;
            default:   funct_map = 4'b0_010;
        endcase
    endfunction

    logic [3:0] fmap;
    assign fmap = funct_map(bus.funct);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d        = state_q;
        bus.iord       = 1'b0;
        bus.irwrite    = 1'b0;
        bus.memwrite   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.pcen       = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = 3'b010;
        bus.instrdone  = 1'b0;

        case (state_q)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                bus.irwrite = bus.memready;
                bus.pcen    = bus.memready;
                if (bus.memready) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_ADDI, OP_ORI:  state_d = S_IMMEX;
                    OP_J:             state_d = S_JUMP;
                    default: begin
                        // Unsupported opcode retires as a no-op.
                        state_d       = S_FETCH;
                        bus.instrdone = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                state_d     = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                if (bus.memready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.memtoreg  = 1'b1;
                bus.regwrite  = 1'b1;
                bus.instrdone = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWR: begin
                bus.iord     = 1'b1;
                bus.memwrite = 1'b1;
                if (bus.memready) begin
                    bus.instrdone = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_EXECUTE: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = fmap[2:0];
                if (fmap[3]) begin
                    state_d = S_ALUWB;
                end else begin
                    bus.instrdone = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_ALUWB: begin
                bus.regdst     = 1'b1;
                bus.regwrite   = 1'b1;
                bus.instrdone  = 1'b1;
                bus.alucontrol = fmap[2:0];
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = 3'b110;
                bus.pcsrc      = 2'b01;
                bus.instrdone  = 1'b1;
                if (bus.op == OP_BEQ)      bus.pcen = bus.zero;
                else if (bus.op == OP_BNE) bus.pcen = ~bus.zero;
                state_d = S_FETCH;
            end
            S_IMMEX: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.alucontrol = (bus.op == OP_ORI) ? 3'b001 : 3'b010;
                state_d        = S_IMMWB;
            end
            S_IMMWB: begin
                bus.regwrite   = 1'b1;
                bus.instrdone  = 1'b1;
                bus.alucontrol = (bus.op == OP_ORI) ? 3'b001 : 3'b010;
                state_d        = S_FETCH;
            end
            S_JUMP: begin
                bus.pcsrc     = 2'b10;
                bus.pcen      = 1'b1;
                bus.instrdone = 1'b1;
                state_d       = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset masks every side-effecting strobe; mux selects still decode.
        if (reset) begin
            bus.pcen      = 1'b0;
            bus.irwrite   = 1'b0;
            bus.regwrite  = 1'b0;
            bus.memwrite  = 1'b0;
            bus.instrdone = 1'b0;
        end
    end

    assign bus.state = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
module tb_mc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mc_sequencer_if bus();

    mc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    logic [4:0] strobes;
    always_comb strobes = {bus.pcen, bus.irwrite, bus.regwrite, bus.memwrite, bus.instrdone};

    initial begin
        reset = 1'b1;
        bus.op = 6'b0; bus.funct = 6'b0; bus.zero = 1'b0; bus.memready = 1'b1;

        // Reset
        step();
        chk("rst_state", bus.state, 0);
        chk("rst_strobes", strobes, 5'b0);
        reset = 1'b0;
        #1;

        // lw: 0,1,2,3,4,0
        bus.op = 6'b100011;
        #1;
        chk("lw_fetch_state", bus.state, 0);
        chk("lw_fetch_irw_pcen", {bus.irwrite, bus.pcen, bus.alusrcb}, 4'b1101);
        step();
        chk("lw_decode", {bus.state, bus.alusrcb, strobes}, {4'd1, 2'b11, 5'b0});
        step();
        chk("lw_memadr", {bus.state, bus.alusrca, bus.alusrcb, bus.alucontrol}, {4'd2, 1'b1, 2'b10, 3'b010});
        step();
        chk("lw_memrd", {bus.state, bus.iord, bus.regwrite, bus.memtoreg, bus.instrdone}, {4'd3, 4'b1000});
        step();
        chk("lw_memwb", {bus.state, bus.regwrite, bus.memtoreg, bus.instrdone}, {4'd4, 3'b111});
        step();
        chk("lw_back", {bus.state, bus.regwrite, bus.instrdone}, {4'd0, 2'b00});

        // sw with 3 stall cycles in MEMWR
        bus.op = 6'b101011;
        step(); step();
        chk("sw_memadr", bus.state, 2);
        step();
        bus.memready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("sw_stall", {bus.state, bus.memwrite, bus.iord, bus.instrdone}, {4'd5, 3'b110});
            step();
        end
        bus.memready = 1'b1;
        #1;
        chk("sw_done", {bus.state, bus.memwrite, bus.iord, bus.instrdone}, {4'd5, 3'b111});
        step();
        chk("sw_back", bus.state, 0);

        // beq taken
        bus.op = 6'b000100; bus.zero = 1'b1;
        step(); step();
        chk("beq_branch", {bus.state, bus.pcen, bus.pcsrc, bus.alucontrol, bus.instrdone}, {4'd8, 1'b1, 2'b01, 3'b110, 1'b1});
        step();
        chk("beq_back", bus.state, 0);

        // bne not taken (zero=1)
        bus.op = 6'b000101;
        step(); step();
        chk("bne_branch", {bus.state, bus.pcen, bus.pcsrc}, {4'd8, 1'b0, 2'b01});
        bus.zero = 1'b0;
        #1;
        chk("bne_taken_zero0", bus.pcen, 1);
        step();
        chk("bne_back", bus.state, 0);

        // R-type slt
        bus.op = 6'b000000; bus.funct = 6'b101010;
        step(); step();
        chk("slt_exec", {bus.state, bus.alucontrol, bus.alusrca, bus.alusrcb, bus.regwrite, bus.instrdone}, {4'd6, 3'b111, 1'b1, 2'b00, 2'b00});
        step();
        chk("slt_aluwb", {bus.state, bus.alucontrol, bus.regdst, bus.regwrite, bus.instrdone}, {4'd7, 3'b111, 3'b111});
        step();
        chk("slt_back", bus.state, 0);

        // R-type sub mapping
        bus.funct = 6'b100010;
        step(); step();
        chk("sub_exec", {bus.state, bus.alucontrol}, {4'd6, 3'b110});
        step(); step();
        chk("sub_back", bus.state, 0);

        // R-type unmapped funct
        bus.funct = 6'b000000;
        step(); step();
        chk("badfunct_exec", {bus.state, bus.regwrite, bus.instrdone}, {4'd6, 2'b01});
        step();
        chk("badfunct_back", {bus.state, bus.regwrite}, {4'd0, 1'b0});

        // ori
        bus.op = 6'b001101;
        step(); step();
        chk("ori_immex", {bus.state, bus.alucontrol, bus.alusrca, bus.alusrcb, bus.regwrite}, {4'd9, 3'b001, 1'b1, 2'b10, 1'b0});
        step();
        chk("ori_immwb", {bus.state, bus.alucontrol, bus.regwrite, bus.regdst, bus.memtoreg, bus.instrdone}, {4'd10, 3'b001, 4'b1001});
        step();
        chk("ori_back", bus.state, 0);

        // addi
        bus.op = 6'b001000;
        step(); step();
        chk("addi_immex", {bus.state, bus.alucontrol}, {4'd9, 3'b010});
        step(); step();
        chk("addi_back", bus.state, 0);

        // j
        bus.op = 6'b000010;
        step(); step();
        chk("j_jump", {bus.state, bus.pcsrc, bus.pcen, bus.instrdone}, {4'd11, 2'b10, 2'b11});
        step();
        chk("j_back", bus.state, 0);

        // illegal opcode
        bus.op = 6'b111111;
        step();
        chk("ill_decode", {bus.state, strobes}, {4'd1, 5'b00001});
        step();
        chk("ill_back", bus.state, 0);

        // reset during MEMRD stall
        bus.op = 6'b100011;
        step(); step(); step();
        bus.memready = 1'b0;
        #1;
        chk("stall_memrd", bus.state, 3);
        step();
        chk("stall_memrd_hold", bus.state, 3);
        reset = 1'b1;
        #1;
        chk("rst_memrd_strobes", strobes, 5'b0);
        step();
        chk("rst_memrd_state", bus.state, 0);
        bus.memready = 1'b1;
        #1;
        chk("rst_fetch_strobes", strobes, 5'b0);
        step();
        chk("rst_hold_state", bus.state, 0);

        // FETCH stall
        reset = 1'b0;
        bus.memready = 1'b0;
        #1;
        chk("fetch_stall_strobes", {bus.irwrite, bus.pcen}, 2'b00);
        step();
        chk("fetch_stall_state", bus.state, 0);
        bus.memready = 1'b1;
        #1;
        chk("fetch_go", {bus.irwrite, bus.pcen}, 2'b11);
        step();
        chk("fetch_to_decode", bus.state, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
